hqm_aw_rf_fifo_ctl_256x20: RTL

HQM_AW_RF_FIFO_CTL_256X20 -- requirements
Module: hqm_aw_rf_fifo_ctl_256x20

---
 rtl/hqm_aw_rf_fifo_ctl_256x20_if.sv | 22 ++
 rtl/hqm_aw_rf_fifo_ctl_256x20.sv | 92 +++++++++
 2 files changed

// File: rtl/hqm_aw_rf_fifo_ctl_256x20_if.sv
// Push/pop stream handshake between a producer/consumer and the RF-backed FIFO controller.
// The master side drives pushes and pop-acks; the slave side is the FIFO.
interface hqm_aw_rf_fifo_ctl_256x20_if #(
  parameter int DWIDTH = 20
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/hqm_aw_rf_fifo_ctl_256x20.sv
// FIFO controller around an external 1-cycle-latency 2-port RF, with a 2-entry
// registered output buffer so the head is always served from flops.
module hqm_aw_rf_fifo_ctl_256x20 #(
  parameter int DEPTH  = 256,
  parameter int DWIDTH = 20,
  parameter int AWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  hqm_aw_rf_fifo_ctl_256x20_if.slave s,
  output logic                     mem_we,
  output logic [AWIDTH-1:0]        mem_waddr,
  output logic [DWIDTH-1:0]        mem_wdata,
  output logic                     mem_re,
  output logic [AWIDTH-1:0]        mem_raddr,
  input  logic [DWIDTH-1:0]        mem_rdata,
  output logic [8:0]               depth,
  output logic                     err_ovf
);
  localparam int CW = AWIDTH + 1;

  logic [AWIDTH-1:0] wptr_q, rptr_q, raddr_q;
  logic [CW-1:0]     mem_cnt_q, mem_cnt_d;
  logic              rd_inflight_q;
  logic [1:0]        ob_cnt_q, ob_cnt_d;
  logic [DWIDTH-1:0] ob0_q, ob1_q;
  logic [8:0]        depth_q;
  logic              push, pop, issue, cap;
  logic [2:0]        occ;

  assign s.in_ready  = (mem_cnt_q < CW'(DEPTH));
  assign s.out_valid = (ob_cnt_q != 2'd0);
  assign s.out_data  = ob0_q;

  assign push = s.in_valid & s.in_ready & ~clr;
  assign pop  = s.out_valid & s.out_ready;
  assign cap  = rd_inflight_q & ~clr;
  // Slots already claimed in the output buffer; a pop this cycle frees one.
  assign occ   = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q};
  assign issue = ~clr & (mem_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop}));

  assign mem_cnt_d = mem_cnt_q + CW'(push) - CW'(issue);
  assign ob_cnt_d  = ob_cnt_q + 2'(cap) - 2'(pop);

  assign mem_we    = push;
  assign mem_waddr = wptr_q;
  assign mem_wdata = s.in_data;
  assign mem_re    = issue;
  assign mem_raddr = issue ? rptr_q : raddr_q;
  assign depth     = depth_q;
  assign err_ovf   = s.in_valid & ~s.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      raddr_q       <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= 2'd0;
      ob0_q         <= '0;
      ob1_q         <= '0;
      depth_q       <= '0;
    end else if (clr) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= 2'd0;
      depth_q       <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == AWIDTH'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
      if (issue) begin
        rptr_q  <= (rptr_q == AWIDTH'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
        raddr_q <= rptr_q;
      end
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= issue;
      ob_cnt_q      <= ob_cnt_d;
      depth_q       <= 9'(mem_cnt_d) + 9'(issue) + 9'(ob_cnt_d);
      // Returning read data lands in the first free slot after any pop shift.
      if (pop) begin
        ob0_q <= (cap && ob_cnt_q == 2'd1) ? mem_rdata : ob1_q;
        if (cap && ob_cnt_q == 2'd2) ob1_q <= mem_rdata;
      end else if (cap) begin
        if (ob_cnt_q == 2'd0) ob0_q <= mem_rdata;
        else                  ob1_q <= mem_rdata;
      end
    end
  end
endmodule
